// File: rtl/rf_pkg.sv
// Shared types and default widths for the register-file writeback unit.
package rf_pkg;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous circular-buffer FIFO with a combinational head read.
// A push and a pop in the same cycle are accepted at any occupancy, including full.
module wb_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write-port arbiter: ALU path has fixed priority, the queued load
// path is forced through after STARVE_LIMIT losses. Optional macro: RF_WB_DROP_R0_EN.
module rf_writeback_unit #(
  parameter int DATA_W       = rf_pkg::DATA_W,
  parameter int ADDR_W       = rf_pkg::ADDR_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_rd,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          RegWrite,
  output logic [ADDR_W-1:0]             WriteReg,
  output logic [DATA_W-1:0]             WriteData,
  output logic [$clog2(FIFO_DEPTH):0]   mem_count
);

  import rf_pkg::*;

  localparam int REQ_W = ADDR_W + DATA_W;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  wb_state_e         state_q;
  logic [SC_W-1:0]   starve_q;
  logic              reg_write_q;
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;

  logic              fifo_full, fifo_empty;
  logic [REQ_W-1:0]  head;
  logic              alu_win, mem_win, any_win, win_we_d;
  logic [ADDR_W-1:0] win_rd_d;
  logic [DATA_W-1:0] win_data_d;

  wb_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_mem_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (mem_valid && mem_ready),
    .wdata_i ({mem_rd, mem_data}),
    .pop_i   (mem_win),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (mem_count)
  );

  assign alu_ready  = (state_q == NORMAL) || fifo_empty;
  assign mem_ready  = !fifo_full;
  assign alu_win    = alu_valid && alu_ready;
  assign mem_win    = !alu_win && !fifo_empty;
  assign any_win    = alu_win || mem_win;
  assign win_rd_d   = alu_win ? alu_rd   : head[REQ_W-1:DATA_W];
  assign win_data_d = alu_win ? alu_data : head[DATA_W-1:0];

`ifdef RF_WB_DROP_R0_EN
  // r0 writes still consume their handshake but never strobe the register file.
  assign win_we_d = any_win && (win_rd_d != '0);
`else
  assign win_we_d = any_win;
`endif

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NORMAL;
      starve_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q <= win_we_d;
      if (any_win) begin
        write_reg_q  <= win_rd_d;
        write_data_q <= win_data_d;
      end
      case (state_q)
        NORMAL: begin
          // The queue loses only when the ALU wins while an entry is waiting.
          if (alu_win && !fifo_empty) begin
            if (starve_q == SC_W'(STARVE_LIMIT - 1)) begin
              state_q  <= FORCE_MEM;
              starve_q <= '0;
            end else begin
              starve_q <= starve_q + SC_W'(1);
            end
          end else begin
            starve_q <= '0;
          end
        end
        FORCE_MEM: begin
          state_q  <= NORMAL;
          starve_q <= '0;
        end
        default: begin
          state_q  <= NORMAL;
          starve_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Self-checking bench for rf_writeback_unit: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_rf_writeback_unit;
  import rf_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
`ifdef RF_WB_DROP_R0_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [3:0]  alu_rd = '0, mem_rd = '0;
  logic [18:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, RegWrite;
  logic [3:0]  WriteReg;
  logic [18:0] WriteData;
  logic [2:0]  mem_count;

  rf_writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .mem_count(mem_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of pending loads plus a count of consecutive losses.
  wb_req_t     mq[$];
  int          m_losses;
  bit          m_force;
  bit          m_we;
  logic [3:0]  m_rd;
  logic [18:0] m_data;
  bit          acc_alu, acc_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_losses = 0; m_force = 0; m_we = 0; m_rd = '0; m_data = '0;
  endtask

  function automatic bit model_alu_ready();
    return !m_force || (mq.size() == 0);
  endfunction

  task automatic model_step();
    bit      waiting, take_alu, take_mem, push;
    wb_req_t r;
    waiting  = mq.size() != 0;
    take_alu = alu_valid && model_alu_ready();
    take_mem = !take_alu && waiting;
    push     = mem_valid && (mq.size() < DEPTH);
    if (take_alu) begin m_rd = alu_rd; m_data = alu_data; end
    else if (take_mem) begin m_rd = mq[0].rd; m_data = mq[0].data; end
    m_we = (take_alu || take_mem) && !(DROP && m_rd == 4'd0);
    if (m_force) begin
      m_force = 0; m_losses = 0;
    end else if (take_alu && waiting) begin
      m_losses++;
      if (m_losses == LIMIT) begin m_force = 1; m_losses = 0; end
    end else begin
      m_losses = 0;
    end
    if (take_mem) void'(mq.pop_front());
    if (push) begin r.rd = mem_rd; r.data = mem_data; mq.push_back(r); end
  endtask

  task automatic cmp_model();
    chk("m_alu_ready", alu_ready, model_alu_ready());
    chk("m_mem_ready", mem_ready, mq.size() < DEPTH);
    chk("m_mem_count", mem_count, mq.size());
    chk("m_RegWrite", RegWrite, m_we);
    chk("m_WriteReg", WriteReg, m_rd);
    chk("m_WriteData", WriteData, m_data);
  endtask

  // One clock: note handshakes, advance the model, sample #1 after the edge.
  task automatic step();
    acc_alu = alu_valid && alu_ready;
    acc_mem = mem_valid && mem_ready;
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic        av; logic [3:0] ar; logic [18:0] ad;
    logic        mv; logic [3:0] mr; logic [18:0] md;
    logic        e_ar, e_mr; logic [2:0] e_cnt;
    logic        e_we; logic [3:0] e_rd; logic [18:0] e_data;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          wins, maxc;
    logic [18:0] held;

    tbl[0] = '{1, 6, 19'h00111, 1, 1, 19'h10001, 1, 1, 1, 1, 6, 19'h00111};
    tbl[1] = '{1, 7, 19'h00222, 1, 2, 19'h10002, 1, 1, 2, 1, 7, 19'h00222};
    tbl[2] = '{1, 8, 19'h00333, 1, 3, 19'h10003, 1, 1, 3, 1, 8, 19'h00333};
    tbl[3] = '{1, 9, 19'h00444, 1, 4, 19'h10004, 0, 0, 4, 1, 9, 19'h00444};
    tbl[4] = '{0, 0, 19'h0,     0, 0, 19'h0,     1, 1, 3, 1, 1, 19'h10001};
    tbl[5] = '{0, 0, 19'h0,     0, 0, 19'h0,     1, 1, 2, 1, 2, 19'h10002};
    tbl[6] = '{0, 0, 19'h0,     0, 0, 19'h0,     1, 1, 1, 1, 3, 19'h10003};
    tbl[7] = '{0, 0, 19'h0,     0, 0, 19'h0,     1, 1, 0, 1, 4, 19'h10004};
    tbl[8] = '{0, 0, 19'h0,     0, 0, 19'h0,     1, 1, 0, 0, 4, 19'h10004};

    // Reset held with an ALU request pending.
    model_reset();
    alu_valid = 1; alu_rd = 4'd5; alu_data = 19'h1ABCD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_WriteReg", WriteReg, 0);
    chk("rst_WriteData", WriteData, 0);
    chk("rst_mem_count", mem_count, 0);
    rst_n = 1;
    step();
    chk("first_accept", acc_alu, 1);
    chk("first_RegWrite", RegWrite, 1);
    chk("first_WriteReg", WriteReg, 5);
    chk("first_WriteData", WriteData, 19'h1ABCD);
    $display("txn reset-release: WriteReg=%0d WriteData=%0h", WriteReg, WriteData);
    alu_valid = 0;
    step();

    // Vector table: fill the queue under ALU pressure, then drain in order.
    for (int i = 0; i < 9; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ar; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mr; mem_data = tbl[i].md;
      step();
      chk($sformatf("vec%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("vec%0d_mem_ready", i), mem_ready, tbl[i].e_mr);
      chk($sformatf("vec%0d_mem_count", i), mem_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_RegWrite", i), RegWrite, tbl[i].e_we);
      chk($sformatf("vec%0d_WriteReg", i), WriteReg, tbl[i].e_rd);
      chk($sformatf("vec%0d_WriteData", i), WriteData, tbl[i].e_data);
      $display("txn vec%0d: we=%0d rd=%0d data=%0h count=%0d", i, RegWrite, WriteReg, WriteData, mem_count);
    end

    // Starvation guard: one queued load against a continuous ALU stream.
    alu_valid = 1; alu_rd = 4'd10; alu_data = 19'h0A0A0;
    mem_valid = 1; mem_rd = 4'd11; mem_data = 19'h2AAAA;
    step();
    chk("starve_push", acc_mem, 1);
    mem_valid = 0;
    wins = 0;
    for (int k = 0; k < 8 && alu_ready; k++) begin
      step();
      if (acc_alu) begin wins++; alu_data = alu_data + 19'd1; end
    end
    chk("starve_alu_wins", wins, LIMIT);
    chk("force_alu_ready", alu_ready, 0);
    held = alu_data;
    step();
    chk("force_no_alu", acc_alu, 0);
    chk("force_WriteReg", WriteReg, 11);
    chk("force_WriteData", WriteData, 19'h2AAAA);
    chk("force_exit_ready", alu_ready, 1);
    step();
    chk("resume_WriteReg", WriteReg, 10);
    chk("resume_WriteData", WriteData, held);
    $display("txn starvation: alu wins before force=%0d", wins);

    // Saturating stream on both paths; payloads only advance on acceptance.
    maxc = 0;
    mem_valid = 1; mem_rd = 4'd1; mem_data = 19'h30000;
    for (int k = 0; k < 40; k++) begin
      step();
      if (acc_alu) begin alu_rd = 4'($urandom_range(1, 15)); alu_data = 19'($urandom); end
      if (acc_mem) begin mem_rd = mem_rd + 4'd1; mem_data = mem_data + 19'd1; end
      if (int'(mem_count) > maxc) maxc = int'(mem_count);
    end
    chk("stream_max_count", maxc, DEPTH);

    // Near-full push/pop pairs with the ALU idle: occupancy holds, order preserved.
    alu_valid = 0;
    repeat (2) begin
      step();
      if (acc_mem) begin mem_rd = mem_rd + 4'd1; mem_data = mem_data + 19'd1; end
    end
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("pp%0d_count", k), mem_count, DEPTH - 1);
      chk($sformatf("pp%0d_pushed", k), acc_mem, 1);
      if (acc_mem) begin mem_rd = mem_rd + 4'd1; mem_data = mem_data + 19'd1; end
    end
    $display("txn push/pop pairs: count=%0d", mem_count);

    // Randomized traffic; payload held while valid && !ready.
    for (int k = 0; k < 300; k++) begin
      if (!alu_valid || acc_alu) begin
        alu_valid = ($urandom_range(0, 2) == 0);
        alu_rd = 4'($urandom); alu_data = 19'($urandom);
      end
      if (!mem_valid || acc_mem) begin
        mem_valid = ($urandom_range(0, 1) == 0);
        mem_rd = 4'($urandom); mem_data = 19'($urandom);
      end
      step();
    end
    $display("txn random: errors so far=%0d", errors);

    // Reset mid-burst with three loads queued and a write on the port.
    alu_valid = 0; mem_valid = 0;
    for (int k = 0; k < 12 && mem_count != 0; k++) step();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 4'(12 + i); alu_data = 19'(19'h500 + i);
      mem_valid = 1; mem_rd = 4'(1 + i); mem_data = 19'(19'h4000 + i);
      step();
    end
    chk("pre_rst_count", mem_count, 3);
    chk("pre_rst_RegWrite", RegWrite, 1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("midrst_RegWrite", RegWrite, 0);
    chk("midrst_count", mem_count, 0);
    alu_valid = 0; mem_valid = 0;
    @(posedge clk);
    #3;
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("postrst%0d_RegWrite", k), RegWrite, 0);
    end
    $display("txn mid-reset: count=%0d", mem_count);

    // Write to r0.
    alu_valid = 1; alu_rd = 4'd0; alu_data = 19'h7FFFF;
    step();
    chk("r0_accept", acc_alu, 1);
    chk("r0_RegWrite", RegWrite, DROP ? 0 : 1);
    chk("r0_WriteReg", WriteReg, 0);
    alu_valid = 0;
    step();
    $display("txn r0 write: RegWrite=%0d", RegWrite);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
